// File: rtl/trap_pkg.sv
// Trap sequencer shared definitions.
//   trap_state_e : sequencer states
//   CAUSE_*      : mcause exception codes (zero-extended to XLEN by users)
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_CSR      = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_HALT     = 3'd4
  } trap_state_e;

  localparam logic [4:0] CAUSE_FETCH_FAULT = 5'd1;
  localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK      = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_FAULT  = 5'd5;
  localparam logic [4:0] CAUSE_STORE_FAULT = 5'd7;
  localparam logic [4:0] CAUSE_ECALL       = 5'd11;

endpackage

// File: rtl/trap_prio.sv
// Combinational oldest-first selection among exception requests.
// Order: lsu_fault > idu_illegal > idu_ebreak > idu_ecall > ifu_fault.
// Ports:
//   ifu_*/idu_*/lsu_* : raw requests and their PC / value operands
//   req_valid         : some request is present
//   req_cause/pc/tval : mcause / mepc / mtval of the winner
//   req_is_ebreak     : winner is an ebreak
module trap_prio
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ifu_fault,
  input  logic [XLEN-1:0] ifu_pc,
  input  logic            idu_illegal,
  input  logic            idu_ebreak,
  input  logic            idu_ecall,
  input  logic [XLEN-1:0] idu_pc,
  input  logic [31:0]     idu_inst,
  input  logic            lsu_fault,
  input  logic            lsu_is_store,
  input  logic [XLEN-1:0] lsu_pc,
  input  logic [XLEN-1:0] lsu_addr,
  output logic            req_valid,
  output logic [XLEN-1:0] req_cause,
  output logic [XLEN-1:0] req_pc,
  output logic [XLEN-1:0] req_tval,
  output logic            req_is_ebreak
);

  function automatic logic [XLEN-1:0] ext_cause(input logic [4:0] c);
    return XLEN'(c);
  endfunction

  always_comb begin
    req_valid     = 1'b1;
    req_cause     = '0;
    req_pc        = '0;
    req_tval      = '0;
    req_is_ebreak = 1'b0;
    if (lsu_fault) begin
      req_cause = ext_cause(lsu_is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT);
      req_pc    = lsu_pc;
      req_tval  = lsu_addr;
    end else if (idu_illegal) begin
      req_cause = ext_cause(CAUSE_ILLEGAL);
      req_pc    = idu_pc;
      req_tval  = XLEN'(idu_inst);
    end else if (idu_ebreak) begin
      req_cause     = ext_cause(CAUSE_EBREAK);
      req_pc        = idu_pc;
      req_tval      = idu_pc;
      req_is_ebreak = 1'b1;
    end else if (idu_ecall) begin
      req_cause = ext_cause(CAUSE_ECALL);
      req_pc    = idu_pc;
    end else if (ifu_fault) begin
      req_cause = ext_cause(CAUSE_FETCH_FAULT);
      req_pc    = ifu_pc;
      req_tval  = ifu_pc;
    end else begin
      req_valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: picks the oldest exception request, then sequences
// flush -> CSR write (mepc/mcause/mtval) -> redirect to mtvec, and emits
// one-cycle err_* report pulses. ebreak may instead park the core in HALT.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   ifu_*/idu_*/lsu_*       : exception requests and operands
//   mtvec                   : trap vector base
//   pipe_empty              : pipeline drained after flush
//   busy                    : sequencer not idle (combinational)
//   flush                   : kill in-flight instructions
//   csr_we, csr_mepc/mcause/mtval : CSR write strobe and latched values
//   redirect_valid/pc/ready : new-PC handshake with IFU
//   err_ebreak/access_fault/invalid_inst : report pulses
// All outputs except busy are registered, decoded from the next state.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ifu_fault,
  input  logic [XLEN-1:0] ifu_pc,
  input  logic            idu_illegal,
  input  logic            idu_ebreak,
  input  logic            idu_ecall,
  input  logic [XLEN-1:0] idu_pc,
  input  logic [31:0]     idu_inst,
  input  logic            lsu_fault,
  input  logic            lsu_is_store,
  input  logic [XLEN-1:0] lsu_pc,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] mtvec,
  input  logic            pipe_empty,
  output logic            busy,
  output logic            flush,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_mepc,
  output logic [XLEN-1:0] csr_mcause,
  output logic [XLEN-1:0] csr_mtval,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            err_ebreak,
  output logic            err_access_fault,
  output logic            err_invalid_inst
);

  localparam logic [XLEN-1:0] MC_FETCH  = XLEN'(CAUSE_FETCH_FAULT);
  localparam logic [XLEN-1:0] MC_ILL    = XLEN'(CAUSE_ILLEGAL);
  localparam logic [XLEN-1:0] MC_EBREAK = XLEN'(CAUSE_EBREAK);
  localparam logic [XLEN-1:0] MC_LOAD   = XLEN'(CAUSE_LOAD_FAULT);
  localparam logic [XLEN-1:0] MC_STORE  = XLEN'(CAUSE_STORE_FAULT);
  localparam logic [XLEN-1:0] PC_MASK   = ~XLEN'(3);

  trap_state_e     state_q, state_d;
  logic            req_valid, req_is_ebreak;
  logic [XLEN-1:0] req_cause, req_pc, req_tval;
  logic            is_ebreak_q;
  logic            flush_d, csr_we_d, redir_d;
  logic            err_ebreak_d, err_access_d, err_invalid_d;

  trap_prio #(.XLEN(XLEN)) u_prio (
    .ifu_fault     (ifu_fault),
    .ifu_pc        (ifu_pc),
    .idu_illegal   (idu_illegal),
    .idu_ebreak    (idu_ebreak),
    .idu_ecall     (idu_ecall),
    .idu_pc        (idu_pc),
    .idu_inst      (idu_inst),
    .lsu_fault     (lsu_fault),
    .lsu_is_store  (lsu_is_store),
    .lsu_pc        (lsu_pc),
    .lsu_addr      (lsu_addr),
    .req_valid     (req_valid),
    .req_cause     (req_cause),
    .req_pc        (req_pc),
    .req_tval      (req_tval),
    .req_is_ebreak (req_is_ebreak)
  );

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    flush_d       = 1'b0;
    csr_we_d      = 1'b0;
    redir_d       = 1'b0;
    err_ebreak_d  = 1'b0;
    err_access_d  = 1'b0;
    err_invalid_d = 1'b0;
    unique case (state_q)
      ST_IDLE:     if (req_valid) state_d = ST_FLUSH;
      // FLUSH is only entered from IDLE, so it always lasts at least one cycle.
      ST_FLUSH:    if (pipe_empty)
                     state_d = (is_ebreak_q && HALT_ON_EBREAK) ? ST_HALT : ST_CSR;
      ST_CSR:      state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_IDLE;
    endcase

    flush_d  = (state_d == ST_FLUSH);
    csr_we_d = (state_d == ST_CSR);
    redir_d  = (state_d == ST_REDIRECT);
    // Report pulses coincide with the CSR cycle, or with HALT entry for a
    // parked ebreak. ecall is a normal service call and is not reported.
    if (state_d == ST_CSR) begin
      err_ebreak_d  = (csr_mcause == MC_EBREAK);
      err_access_d  = (csr_mcause == MC_FETCH) || (csr_mcause == MC_LOAD) ||
                      (csr_mcause == MC_STORE);
      err_invalid_d = (csr_mcause == MC_ILL);
    end
    if ((state_d == ST_HALT) && (state_q != ST_HALT)) err_ebreak_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      is_ebreak_q      <= 1'b0;
      csr_mepc         <= '0;
      csr_mcause       <= '0;
      csr_mtval        <= '0;
      redirect_pc      <= '0;
      flush            <= 1'b0;
      csr_we           <= 1'b0;
      redirect_valid   <= 1'b0;
      err_ebreak       <= 1'b0;
      err_access_fault <= 1'b0;
      err_invalid_inst <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush            <= flush_d;
      csr_we           <= csr_we_d;
      redirect_valid   <= redir_d;
      err_ebreak       <= err_ebreak_d;
      err_access_fault <= err_access_d;
      err_invalid_inst <= err_invalid_d;
      if ((state_q == ST_IDLE) && req_valid) begin
        csr_mepc    <= req_pc;
        csr_mcause  <= req_cause;
        csr_mtval   <= req_tval;
        is_ebreak_q <= req_is_ebreak;
      end
      // Captured once on entry so the target stays put while waiting for ready.
      if ((state_q == ST_CSR) && (state_d == ST_REDIRECT))
        redirect_pc <= mtvec & PC_MASK;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: one instance with ebreak halting, one with
// ebreak trapping, sharing the same stimulus.
module tb_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ifu_fault, idu_illegal, idu_ebreak, idu_ecall;
  logic        lsu_fault, lsu_is_store, pipe_empty, redirect_ready;
  logic [31:0] ifu_pc, idu_pc, idu_inst, lsu_pc, lsu_addr, mtvec;

  logic        busy, flush, csr_we, redirect_valid;
  logic        err_ebreak, err_access_fault, err_invalid_inst;
  logic [31:0] csr_mepc, csr_mcause, csr_mtval, redirect_pc;

  logic        n_busy, n_flush, n_csr_we, n_redirect_valid;
  logic        n_err_ebreak, n_err_access_fault, n_err_invalid_inst;
  logic [31:0] n_csr_mepc, n_csr_mcause, n_csr_mtval, n_redirect_pc;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_ebk = 0, cnt_acc = 0, cnt_inv = 0;
  int n_cnt_ebk = 0, n_cnt_acc = 0, n_cnt_inv = 0;
  int b_ebk, b_acc, b_inv, b_nebk;

  always #5 clock = ~clock;

  trap_ctrl #(.XLEN(32), .HALT_ON_EBREAK(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .ifu_fault(ifu_fault), .ifu_pc(ifu_pc),
    .idu_illegal(idu_illegal), .idu_ebreak(idu_ebreak), .idu_ecall(idu_ecall),
    .idu_pc(idu_pc), .idu_inst(idu_inst),
    .lsu_fault(lsu_fault), .lsu_is_store(lsu_is_store), .lsu_pc(lsu_pc),
    .lsu_addr(lsu_addr), .mtvec(mtvec), .pipe_empty(pipe_empty),
    .busy(busy), .flush(flush), .csr_we(csr_we),
    .csr_mepc(csr_mepc), .csr_mcause(csr_mcause), .csr_mtval(csr_mtval),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .err_ebreak(err_ebreak), .err_access_fault(err_access_fault),
    .err_invalid_inst(err_invalid_inst)
  );

  trap_ctrl #(.XLEN(32), .HALT_ON_EBREAK(1'b0)) dut_nh (
    .clock(clock), .reset_n(reset_n),
    .ifu_fault(ifu_fault), .ifu_pc(ifu_pc),
    .idu_illegal(idu_illegal), .idu_ebreak(idu_ebreak), .idu_ecall(idu_ecall),
    .idu_pc(idu_pc), .idu_inst(idu_inst),
    .lsu_fault(lsu_fault), .lsu_is_store(lsu_is_store), .lsu_pc(lsu_pc),
    .lsu_addr(lsu_addr), .mtvec(mtvec), .pipe_empty(pipe_empty),
    .busy(n_busy), .flush(n_flush), .csr_we(n_csr_we),
    .csr_mepc(n_csr_mepc), .csr_mcause(n_csr_mcause), .csr_mtval(n_csr_mtval),
    .redirect_valid(n_redirect_valid), .redirect_pc(n_redirect_pc),
    .redirect_ready(redirect_ready),
    .err_ebreak(n_err_ebreak), .err_access_fault(n_err_access_fault),
    .err_invalid_inst(n_err_invalid_inst)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    cnt_ebk   += int'(err_ebreak);
    cnt_acc   += int'(err_access_fault);
    cnt_inv   += int'(err_invalid_inst);
    n_cnt_ebk += int'(n_err_ebreak);
    n_cnt_acc += int'(n_err_access_fault);
    n_cnt_inv += int'(n_err_invalid_inst);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    ifu_fault = 0; idu_illegal = 0; idu_ebreak = 0; idu_ecall = 0;
    lsu_fault = 0; lsu_is_store = 0;
  endtask

  task automatic snap();
    b_ebk = cnt_ebk; b_acc = cnt_acc; b_inv = cnt_inv; b_nebk = n_cnt_ebk;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 0;
    clear_req();
    ifu_pc = 0; idu_pc = 0; idu_inst = 0; lsu_pc = 0; lsu_addr = 0;
    mtvec = 32'h0000_1003; pipe_empty = 1; redirect_ready = 1;
    tick(); tick();
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_csrwe", {31'd0, csr_we}, 0);
    chk("rst_rv",    {31'd0, redirect_valid}, 0);
    chk("rst_mepc",  csr_mepc, 0);
    chk("rst_mcause", csr_mcause, 0);
    chk("rst_mtval", csr_mtval, 0);
    chk("rst_err",   {29'd0, err_ebreak, err_access_fault, err_invalid_inst}, 0);
    reset_n = 1;
    tick();

    // 1: load access fault
    snap();
    lsu_fault = 1; lsu_addr = 32'h8000_0010; lsu_pc = 32'h8000_0100;
    tick();
    clear_req();
    chk("t1_flush",  {31'd0, flush}, 1);
    chk("t1_busy",   {31'd0, busy}, 1);
    chk("t1_csrwe0", {31'd0, csr_we}, 0);
    chk("t1_mcause", csr_mcause, 32'd5);
    chk("t1_mtval",  csr_mtval, 32'h8000_0010);
    chk("t1_mepc",   csr_mepc, 32'h8000_0100);
    tick();
    chk("t1_csrwe",  {31'd0, csr_we}, 1);
    chk("t1_acc",    {31'd0, err_access_fault}, 1);
    chk("t1_flush0", {31'd0, flush}, 0);
    tick();
    chk("t1_rv",     {31'd0, redirect_valid}, 1);
    chk("t1_rpc",    redirect_pc, 32'h0000_1000);
    chk("t1_csrwe1", {31'd0, csr_we}, 0);
    tick();
    chk("t1_rv0",    {31'd0, redirect_valid}, 0);
    chk("t1_idle",   {31'd0, busy}, 0);
    chk("t1_nacc",   cnt_acc - b_acc, 1);

    // 2: illegal beats simultaneous fetch fault
    snap();
    idu_illegal = 1; ifu_fault = 1; idu_inst = 32'hFFFF_FFFF;
    idu_pc = 32'h0000_0200; ifu_pc = 32'h0000_0300;
    tick();
    clear_req();
    chk("t2_mcause", csr_mcause, 32'd2);
    chk("t2_mtval",  csr_mtval, 32'hFFFF_FFFF);
    chk("t2_mepc",   csr_mepc, 32'h0000_0200);
    wait_idle("t2_idle");
    chk("t2_ninv",   cnt_inv - b_inv, 1);
    chk("t2_nacc",   cnt_acc - b_acc, 0);

    // 3: pipeline slow to drain
    pipe_empty = 0;
    ifu_fault = 1; ifu_pc = 32'h0000_0304;
    tick();
    clear_req();
    for (int i = 0; i < 5; i++) begin
      chk("t3_flush", {31'd0, flush}, 1);
      chk("t3_csrwe", {31'd0, csr_we}, 0);
      if (i < 4) tick();
    end
    pipe_empty = 1;
    tick();
    chk("t3_csrwe1", {31'd0, csr_we}, 1);
    chk("t3_mcause", csr_mcause, 32'd1);
    chk("t3_mtval",  csr_mtval, 32'h0000_0304);
    wait_idle("t3_idle");

    // 4: store fault beats illegal; IFU stalls the redirect
    redirect_ready = 0;
    mtvec = 32'h0000_2002;
    lsu_fault = 1; lsu_is_store = 1; lsu_addr = 32'h8000_0020;
    lsu_pc = 32'h8000_0104; idu_illegal = 1;
    tick();
    clear_req();
    chk("t4_mcause", csr_mcause, 32'd7);
    chk("t4_mtval",  csr_mtval, 32'h8000_0020);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_rv",  {31'd0, redirect_valid}, 1);
      chk("t4_rpc", redirect_pc, 32'h0000_2000);
      tick();
    end
    chk("t4_rv_hold", {31'd0, redirect_valid}, 1);
    redirect_ready = 1;
    tick();
    chk("t4_rv0", {31'd0, redirect_valid}, 0);
    chk("t4_idle", {31'd0, busy}, 0);

    // 5: ebreak halts one instance, traps in the other
    snap();
    idu_ebreak = 1; idu_pc = 32'h0000_0400;
    tick();
    clear_req();
    chk("t5_nflush",  {31'd0, n_flush}, 1);
    tick();
    chk("t5_ebk",     {31'd0, err_ebreak}, 1);
    chk("t5_csrwe",   {31'd0, csr_we}, 0);
    chk("t5_flush",   {31'd0, flush}, 0);
    chk("t5_ncsrwe",  {31'd0, n_csr_we}, 1);
    chk("t5_nebk",    {31'd0, n_err_ebreak}, 1);
    chk("t5_nmcause", n_csr_mcause, 32'd3);
    chk("t5_nmtval",  n_csr_mtval, 32'h0000_0400);
    chk("t5_nmepc",   n_csr_mepc, 32'h0000_0400);
    tick();
    chk("t5_ebk0",    {31'd0, err_ebreak}, 0);
    chk("t5_nrv",     {31'd0, n_redirect_valid}, 1);
    chk("t5_nrpc",    n_redirect_pc, 32'h0000_2000);
    repeat (4) tick();
    chk("t5_busy",    {31'd0, busy}, 1);
    chk("t5_csrwe2",  {31'd0, csr_we}, 0);
    chk("t5_nbusy",   {31'd0, n_busy}, 0);
    chk("t5_cnt",     cnt_ebk - b_ebk, 1);
    chk("t5_ncnt",    n_cnt_ebk - b_nebk, 1);
    reset_n = 0;
    #1;
    chk("t5_rst",     {31'd0, busy}, 0);
    tick();
    reset_n = 1;
    tick();

    // 6: reset during FLUSH, then an ecall
    pipe_empty = 0;
    idu_ecall = 1; idu_pc = 32'h0000_0600;
    tick();
    clear_req();
    tick();
    chk("t6_flush", {31'd0, flush}, 1);
    #3;
    reset_n = 0;
    #1;
    chk("t6_flush0",  {31'd0, flush}, 0);
    chk("t6_busy0",   {31'd0, busy}, 0);
    chk("t6_mcause0", csr_mcause, 0);
    #2;
    reset_n = 1;
    pipe_empty = 1;
    tick();
    snap();
    idu_ecall = 1; idu_pc = 32'h0000_0700;
    tick();
    clear_req();
    chk("t6_mcause", csr_mcause, 32'd11);
    chk("t6_mtval",  csr_mtval, 32'd0);
    chk("t6_mepc",   csr_mepc, 32'h0000_0700);
    tick();
    chk("t6_csrwe",  {31'd0, csr_we}, 1);
    wait_idle("t6_idle");
    chk("t6_noerr",  (cnt_ebk - b_ebk) + (cnt_acc - b_acc) + (cnt_inv - b_inv), 0);
    chk("t_nh_acc_inv", n_cnt_acc + n_cnt_inv, cnt_acc + cnt_inv);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
